// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter shared types.
// Owner/state encodings and byte-enable constants.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    localparam int CNT_W  = 4;
    localparam int BE_MAX = 16;
    localparam logic [BE_MAX-1:0] BE_ALL = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory bus bundle.
// slave = arbiter view, master = surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    if_req;
    logic [ADDR_WIDTH-1:0]   if_addr;
    logic                    if_flush;
    logic                    if_ready;
    logic [DATA_WIDTH-1:0]   if_rdata;

    logic                    d_req;
    logic                    d_we;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [DATA_WIDTH/8-1:0] d_be;
    logic                    d_ready;
    logic [DATA_WIDTH-1:0]   d_rdata;

    logic                    m_req;
    logic                    m_we;
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_be;
    logic                    m_gnt;
    logic                    m_rvalid;
    logic [DATA_WIDTH-1:0]   m_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  m_gnt, m_rvalid, m_rdata,
        output if_ready, if_rdata,
        output d_ready, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_be
    );

    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output m_gnt, m_rvalid, m_rdata,
        input  if_ready, if_rdata,
        input  d_ready, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_be
    );

endinterface

// File: rtl/mem_port_arbiter_arb_priority.sv
// Winner pick between fetch and data.
// Data normally wins; a starved fetch overrides it.
module arb_priority
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output owner_t           pick
);

    logic starved;
    logic fetch_win;
    logic data_win;

    assign starved   = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign fetch_win = if_req && (starved || !d_req);
    assign data_win  = d_req && !fetch_win;

    // one-hot decode of the winner
    always_comb begin
        pick = OWN_NONE;
        unique case (1'b1)
            fetch_win: pick = OWN_IF;
            data_win:  pick = OWN_D;
            default:   pick = OWN_NONE;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch and load/store.
// One transaction outstanding; responses routed to owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int BW = DATA_WIDTH / 8;

    arb_state_t            state_q, state_d;
    owner_t                owner_q, owner_d;
    owner_t                pick;
    logic                  kill_q, kill_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BW-1:0]         be_q, be_d;
    logic                  fetch_pend;
    logic                  if_flush_hit;

    assign fetch_pend   = bus.if_req && !bus.if_flush;
    assign if_flush_hit = (owner_q == OWN_IF) && bus.if_flush;

    arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .if_req     (fetch_pend),
        .d_req      (bus.d_req),
        .starve_cnt (cnt_q),
        .pick       (pick)
    );

    assign bus.m_we    = we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.m_be    = be_q;

    // state, owner and latched request fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
            kill_q  <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            kill_q  <= kill_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // next state, grant latching and response routing
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        kill_d       = kill_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        bus.m_req    = 1'b0;
        bus.if_ready = 1'b0;
        bus.if_rdata = '0;
        bus.d_ready  = 1'b0;
        bus.d_rdata  = '0;
        unique case (state_q)
            ARB_IDLE: begin
                owner_d = OWN_NONE;
                kill_d  = 1'b0;
                if (!fetch_pend) cnt_d = '0;
                unique case (pick)
                    OWN_IF: begin
                        we_d    = 1'b0;
                        addr_d  = bus.if_addr;
                        wdata_d = '0;
                        be_d    = BE_ALL[BW-1:0];
                        owner_d = OWN_IF;
                        cnt_d   = '0;
                        state_d = ARB_REQ;
                    end
                    OWN_D: begin
                        we_d    = bus.d_we;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        be_d    = bus.d_be;
                        owner_d = OWN_D;
                        if (fetch_pend && cnt_q != CNT_W'(STARVE_LIMIT))
                            cnt_d = cnt_q + CNT_W'(1);
                        state_d = ARB_REQ;
                    end
                    default: ;
                endcase
            end
            ARB_REQ: begin
                bus.m_req = 1'b1;
                if (if_flush_hit) kill_d = 1'b1;
                if (bus.m_gnt) state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (if_flush_hit) kill_d = 1'b1;
                if (bus.m_rvalid) begin
                    state_d = ARB_IDLE;
                    owner_d = OWN_NONE;
                    kill_d  = 1'b0;
                    if (owner_q == OWN_D) begin
                        bus.d_ready = 1'b1;
                        bus.d_rdata = bus.m_rdata;
                    end else if (owner_q == OWN_IF && !kill_q && !bus.if_flush) begin
                        bus.if_ready = 1'b1;
                        bus.if_rdata = bus.m_rdata;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF-stage fetch path and the MEM-stage load/store path.
- Accepts one request per side, grants one at a time, and drives a req/gnt/rvalid memory handshake with at most one transaction outstanding.
- Routes the response back to its owner.
- Supports cancellation of an in-flight fetch on a branch/jump redirect, and bounds fetch starvation.

Parameters:
- DATA_WIDTH, 32, data and instruction width
- ADDR_WIDTH, 32, byte address width
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits before fetch is forced to win (1..15)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ready or if_flush
- if_addr  in  ADDR_WIDTH  fetch address (pcF)
- if_flush  in  1  redirect; kill the current/pending fetch
- if_ready  out  1  fetch response valid (1-cycle pulse)
- if_rdata  out  DATA_WIDTH  fetched instruction
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_be  in  DATA_WIDTH/8  byte enables
- d_ready  out  1  data transaction complete (1-cycle pulse; load data valid)
- d_rdata  out  DATA_WIDTH  load data
- m_req  out  1  memory request
- m_we  out  1  memory write
- m_addr  out  ADDR_WIDTH  memory address
- m_wdata  out  DATA_WIDTH  memory write data
- m_be  out  DATA_WIDTH/8  memory byte enables
- m_gnt  in  1  memory accepted request this cycle
- m_rvalid  in  1  memory response valid (also sent for writes)
- m_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Reset (rst=0, async): state IDLE, owner=NONE, kill=0, starve_cnt=0; m_req, m_we, m_addr, m_wdata, m_be = 0; if_ready = d_ready = 0.
- States: IDLE, REQ, WAIT.
- IDLE
  - Arbitrate among if_req (gated by !if_flush) and d_req.
  - Data wins, unless starve_cnt == STARVE_LIMIT and a fetch is pending; then fetch wins.
  - The winner's we/addr/wdata/be are latched into registers (fetch: we=0, be=all ones). Set owner and move to REQ.
  - Nothing pending: stay in IDLE.
- REQ
  - m_req=1 with the latched fields, held stable until m_gnt=1, then go to WAIT.
  - m_req is never retracted before m_gnt.
- WAIT
  - m_req=0. On m_rvalid=1, go to IDLE.
  - If owner is data: d_ready=1 and d_rdata=m_rdata, combinational in the same cycle.
  - If owner is fetch and kill=0: if_ready=1 and if_rdata=m_rdata.
  - If owner is fetch and kill=1: the response is dropped (no if_ready) and kill clears.
- Minimum latency: request seen in IDLE at cycle 0, m_req at cycle 1, ready in the cycle m_rvalid arrives (≥ cycle 2 with a zero-wait memory).
- New arbitration happens in the cycle after WAIT exits (no back-to-back overlap).
- Flush rules:
  - if_flush while owner=fetch in REQ or WAIT sets kill.
  - if_flush in the same cycle as m_rvalid also drops the response.
  - if_flush in IDLE suppresses that cycle's fetch candidate.
  - if_flush while owner=data has no effect on the data transaction.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while a fetch is pending.
  - Clears on any fetch grant, and on any IDLE cycle with no fetch pending.
- if_rdata / d_rdata are 0 whenever their ready is low.
- Requesters must hold req and fields until their ready, but fields are latched at grant, so later changes do not affect the issued transaction.
- m_rvalid outside WAIT is ignored; this covers a stale response after reset.
- Reset mid-transaction: immediate return to IDLE with all outputs 0; the requesters reissue.

Decomposition:
- Shared package (pipeline pkg):
  - owner_t enum {OWN_NONE, OWN_IF, OWN_D}
  - arb_state_t enum {ARB_IDLE, ARB_REQ, ARB_WAIT}
  - constant BE_ALL
- One sub-module: arb_priority, a combinational pick of winner from (if_req, d_req, starve_cnt, STARVE_LIMIT).
- FSM, latches and response routing stay in the top.

Test Plan:
- Fetch only, if_addr=0x0000_0010, m_gnt=1 immediately, m_rvalid the next cycle with m_rdata=0x0050_0093 -> m_addr=0x10 with m_we=0; if_ready pulses once with if_rdata=0x0050_0093; d_ready stays 0.
- if_req and d_req (store, addr 0x100, wdata 0xDEAD_BEEF, be=4'b0011) in the same cycle -> data granted first (m_we=1, m_be=0011); d_ready on rvalid; fetch granted in the following IDLE.
- d_req held high continuously with fetch pending, STARVE_LIMIT=4 -> exactly 4 data transactions complete, then the fetch is granted; the counter returns to 0.
- if_flush pulsed while the fetch is in WAIT, then m_rvalid with 0x1234_5678 -> no if_ready; state returns to IDLE; a new fetch at 0x200 issues next and returns correctly.
- m_gnt held low 3 cycles in REQ -> m_req and m_addr stay stable all 3 cycles; the transition happens only on the gnt cycle.
- rst asserted low in WAIT, then released, then a stray m_rvalid -> all outputs 0 immediately; the stray rvalid produces no ready pulse.
